// File: rtl/beep_pkg.sv
// beep_pkg: shared state codes, key indices and tone half-period helper for beep_pattern_ctrl.
package beep_pkg;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CONT = 2'd1;
   localparam state_t ST_ON   = 2'd2;
   localparam state_t ST_OFF  = 2'd3;
   localparam int KEY_TOGGLE = 0;
   localparam int KEY_BURST  = 1;
   localparam int KEY_TONE   = 2;
   function automatic logic [31:0] half_period(input int unsigned base, input logic [7:0] idx);
      return base >> idx;
   endfunction
endpackage

// File: rtl/beep_tone_gen.sv
// beep_tone_gen: half-period counter and square toggle driving the passive buzzer tone.
module beep_tone_gen #(
   parameter int CW = 16
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          en,
   input  logic          restart,
   input  logic [CW-1:0] half,
   output logic          square
);
   logic [CW-1:0] r_cnt;
   logic          r_sq;
   assign square = r_sq;
   always_ff @(posedge sys_clk) begin
      if (sys_rst || !en) begin
         r_cnt <= '0;
         r_sq  <= 1'b0;
      end else if (restart) begin
         r_cnt <= '0;
      end else if (r_cnt == half - 1'b1) begin
         r_cnt <= '0;
         r_sq  <= ~r_sq;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/beep_pattern_ctrl.sv
// beep_pattern_ctrl: toggle/burst/tone key controller for a buzzer pin.
// Define BEEP_TONE_EN for the passive-buzzer square-wave build; otherwise beep is a plain level.
module beep_pattern_ctrl
   import beep_pkg::*;
#(
   parameter int BASE_HALF    = 50000,
   parameter int NUM_TONES    = 4,
   parameter int BURST_BEEPS  = 3,
   parameter int BEEP_ON_CYC  = 5000000,
   parameter int BEEP_OFF_CYC = 5000000
) (
   input  logic                             sys_clk,
   input  logic                             sys_rst,
   input  logic [2:0]                       key_flag,
   input  logic [2:0]                       key_value,
   output logic                             beep,
   output logic                             busy,
   output logic [$clog2(NUM_TONES)-1:0]     tone_idx,
   output logic [$clog2(BURST_BEEPS+1)-1:0] beeps_left
);
   localparam int LW   = $clog2(BURST_BEEPS + 1);
   localparam int PMAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
   localparam int PW   = $clog2(PMAX + 1);
   localparam logic [PW-1:0] ON_LAST  = PW'(BEEP_ON_CYC - 1);
   localparam logic [PW-1:0] OFF_LAST = PW'(BEEP_OFF_CYC - 1);
   localparam logic [LW-1:0] FULL     = LW'(BURST_BEEPS);

   logic [2:0]    w_press;
   logic          w_tog, w_bst, w_aud, w_inburst, w_done, w_phclr, w_beep_d;
   state_t        r_state, w_nstate;
   logic [PW-1:0] r_ph;
   logic [LW-1:0] r_left, w_nleft;
   logic          r_beep;

   assign w_press   = key_flag & ~key_value;
   assign w_tog     = w_press[KEY_TOGGLE];
   assign w_bst     = w_press[KEY_BURST];
   assign w_aud     = (r_state == ST_CONT) || (r_state == ST_ON);
   assign w_inburst = (r_state == ST_ON) || (r_state == ST_OFF);
   assign w_done    = (r_state == ST_ON) ? (r_ph == ON_LAST) : (r_ph == OFF_LAST);
   // A burst restart stays in BURST_ON but must still begin a fresh on-window.
   assign w_phclr   = (w_nstate != r_state) || (w_bst && !w_tog && w_inburst);
   assign busy      = r_state != ST_IDLE;
   assign beeps_left = r_left;
   assign beep      = r_beep;

   always_comb begin
      w_nstate = r_state;
      w_nleft  = r_left;
      if (r_state == ST_IDLE) begin
         if (w_tog) w_nstate = ST_CONT;
         else if (w_bst) begin
            w_nstate = ST_ON;
            w_nleft  = FULL;
         end
      end else if (r_state == ST_CONT) begin
         if (w_tog) w_nstate = ST_IDLE;
      end else if (w_tog) begin
         w_nstate = ST_IDLE;
         w_nleft  = '0;
      end else if (w_bst) begin
         w_nstate = ST_ON;
         w_nleft  = FULL;
      end else if (w_done) begin
         if (r_state == ST_ON) w_nstate = ST_OFF;
         else if (r_left > LW'(1)) begin
            w_nstate = ST_ON;
            w_nleft  = r_left - 1'b1;
         end else begin
            w_nstate = ST_IDLE;
            w_nleft  = '0;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= ST_IDLE;
         r_ph    <= '0;
         r_left  <= '0;
         r_beep  <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_ph    <= (w_phclr || !w_inburst) ? '0 : r_ph + 1'b1;
         r_left  <= w_nleft;
         r_beep  <= w_beep_d;
      end
   end

`ifdef BEEP_TONE_EN
   localparam int CW = $clog2(BASE_HALF + 1);
   localparam int TW = $clog2(NUM_TONES);
   logic [TW-1:0] r_tone;
   logic          w_tone, w_sq;
   assign w_tone   = w_press[KEY_TONE];
   assign tone_idx = r_tone;
   // Gating with audible keeps a stale square level from leaking out after the state drops.
   assign w_beep_d = w_aud & w_sq;
   always_ff @(posedge sys_clk) begin
      if (sys_rst) r_tone <= '0;
      else if (w_tone) r_tone <= (r_tone == TW'(NUM_TONES - 1)) ? '0 : r_tone + 1'b1;
   end
   beep_tone_gen #(.CW(CW)) u_tone (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .en      (w_aud),
      .restart (w_tone),
      .half    (CW'(half_period(BASE_HALF, 8'(r_tone)))),
      .square  (w_sq)
   );
`else
   logic w_unused_tone;
   assign w_unused_tone = w_press[KEY_TONE];
   assign tone_idx = '0;
   assign w_beep_d = w_aud;
`endif
endmodule

// File: tb/tb_beep_pattern_ctrl.sv
// tb_beep_pattern_ctrl: directed scenarios plus random key traffic checked against a behavioural model.
`timescale 1ns/1ps
module tb_beep_pattern_ctrl;
   localparam int BH = 8, NT = 4, BB = 3, ON = 20, OFF = 10;
`ifdef BEEP_TONE_EN
   localparam bit TONE = 1'b1;
`else
   localparam bit TONE = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] key_flag = '0;
   logic [2:0] key_value = '1;
   logic       beep, busy;
   logic [1:0] tone_idx, beeps_left;
   int tests = 0, fails = 0;
   // Model: mode 0 idle, 1 continuous, 2 burst beep, 3 burst gap; square = parity of elapsed half-periods.
   int m_mode = 0, m_t = 0, m_left = 0, m_tone = 0, m_run = 0, m_base = 0, m_beep = 0;

   always #5 clk = ~clk;

   beep_pattern_ctrl #(
      .BASE_HALF(BH), .NUM_TONES(NT), .BURST_BEEPS(BB), .BEEP_ON_CYC(ON), .BEEP_OFF_CYC(OFF)
   ) dut (
      .sys_clk(clk), .sys_rst(rst), .key_flag(key_flag), .key_value(key_value),
      .beep(beep), .busy(busy), .tone_idx(tone_idx), .beeps_left(beeps_left)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model(input logic [2:0] p, input logic r);
      int h, nm;
      bit aud, sq, rph;
      if (r) begin
         m_mode = 0; m_t = 0; m_left = 0; m_tone = 0; m_run = 0; m_base = 0; m_beep = 0;
         return;
      end
      h   = BH >> m_tone;
      aud = (m_mode == 1) || (m_mode == 2);
      sq  = ((m_base + m_run / h) % 2) == 1;
      m_beep = (aud && (sq || !TONE)) ? 1 : 0;
      if (!aud) begin
         m_run = 0; m_base = 0;
      end else if (TONE && p[2]) begin
         m_base = sq ? 1 : 0; m_run = 0;
      end else m_run++;
      nm = m_mode; rph = 0;
      if (p[0]) begin
         nm = (m_mode == 0) ? 1 : 0;
         if (m_mode >= 2) m_left = 0;
      end else if (p[1] && m_mode != 1) begin
         nm = 2; m_left = BB; rph = 1;
      end else if (m_mode == 2 && m_t + 1 == ON) nm = 3;
      else if (m_mode == 3 && m_t + 1 == OFF) begin
         if (m_left > 1) begin nm = 2; m_left--; end
         else begin nm = 0; m_left = 0; end
      end
      m_t = (nm != m_mode || rph) ? 0 : m_t + 1;
      m_mode = nm;
      if (TONE && p[2]) m_tone = (m_tone + 1) % NT;
   endtask

   task automatic cyc(input logic [2:0] f, input logic [2:0] v, input logic r);
      key_flag = f; key_value = v; rst = r;
      @(posedge clk);
      model(f & ~v, r);
      @(negedge clk);
      chk("beep", beep, m_beep);
      chk("busy", busy, (m_mode != 0) ? 1 : 0);
      chk("tone_idx", tone_idx, m_tone);
      chk("beeps_left", beeps_left, m_left);
      key_flag = '0; key_value = '1; rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(3'b000, 3'b111, 1'b0);
   endtask

   task automatic press(input logic [2:0] m);
      cyc(m, ~m, 1'b0);
   endtask

   initial begin
      int k;
      logic lvl;
      cyc(3'b000, 3'b111, 1'b1);
      cyc(3'b000, 3'b111, 1'b1);
      chk("rst_beep", beep, 0);
      chk("rst_busy", busy, 0);
      press(3'b001);
      chk("cont_busy", busy, 1);
      for (k = 0; k < 100 && beep !== 1'b1; k++) idle(1);
      chk("first_rise", k, TONE ? 9 : 1);
`ifdef BEEP_TONE_EN
      for (k = 0; k < 100 && beep === 1'b1; k++) idle(1);
      chk("high_len", k, 8);
      for (k = 0; k < 100 && beep === 1'b0; k++) idle(1);
      chk("low_len", k, 8);
`endif
      press(3'b001);
      chk("off_busy", busy, 0);
      idle(1);
      chk("off_beep", beep, 0);
      press(3'b010);
      chk("burst_left", beeps_left, 3);
      for (k = 0; k < 200 && busy !== 1'b0; k++) idle(1);
      chk("burst_len", k, 90);
      press(3'b010);
      idle(35);
      chk("mid_left", beeps_left, 2);
      press(3'b010);
      chk("restart_left", beeps_left, 3);
      for (k = 0; k < 200 && busy !== 1'b0; k++) idle(1);
      chk("restart_len", k, 90);
      press(3'b010);
      idle(25);
      press(3'b001);
      chk("abort_busy", busy, 0);
      chk("abort_left", beeps_left, 0);
      idle(1);
      chk("abort_beep", beep, 0);
      press(3'b001);
      for (int i = 0; i < 4; i++) begin
         press(3'b100);
         chk("tone_step", tone_idx, TONE ? (i + 1) % NT : 0);
`ifdef BEEP_TONE_EN
         lvl = beep;
         for (k = 0; k < 50 && beep === lvl; k++) idle(1);
         lvl = beep;
         for (k = 0; k < 50 && beep === lvl; k++) idle(1);
         chk("half_period", k, BH >> ((i + 1) % NT));
`endif
      end
      press(3'b001);
      cyc(3'b011, 3'b100, 1'b0);
      chk("both_busy", busy, 1);
      chk("both_left", beeps_left, 0);
      press(3'b001);
      cyc(3'b111, 3'b111, 1'b0);
      chk("release_busy", busy, 0);
      press(3'b010);
      idle(15);
      cyc(3'b000, 3'b111, 1'b1);
      chk("mrst_beep", beep, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_left", beeps_left, 0);
      repeat (3000) begin
         logic [2:0] f, v;
         for (int b = 0; b < 3; b++) begin
            f[b] = ($urandom_range(23) == 0);
            v[b] = ($urandom_range(4) == 0);
         end
         cyc(f, v, $urandom_range(599) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/beep_pattern_ctrl.md
# beep_pattern_ctrl

Buzzer controller with three key inputs: continuous on/off toggle, fixed-count beep bursts, and tone selection. Parametrised successor to the single-key toggle beeper. Sits between the key debouncer (one-cycle `key_flag` pulses plus debounced `key_value` levels) and the buzzer pin. Drives either a square-wave tone for a passive buzzer or a plain level for an active buzzer.

## Interface
- `BASE_HALF`, 50000: half-period of tone 0, in `sys_clk` cycles (500 Hz at 50 MHz).
- `NUM_TONES`, 4: tone count. Tone i half-period = `BASE_HALF >> i`. Must be ≤ 8, and `BASE_HALF >> (NUM_TONES-1)` must be ≥ 1.
- `BURST_BEEPS`, 3: beeps per burst, ≥ 1.
- `BEEP_ON_CYC`, 5000000: burst on-time in cycles, ≥ 1.
- `BEEP_OFF_CYC`, 5000000: burst gap in cycles, ≥ 1.
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `key_flag` in 3: one-cycle debounced event per key. [0] = toggle, [1] = burst, [2] = tone.
- `key_value` in 3: debounced key level. 0 = pressed.
- `beep` out 1: buzzer drive, registered.
- `busy` out 1: high in CONT, BURST_ON and BURST_OFF.
- `tone_idx` out clog2(NUM_TONES): current tone.
- `beeps_left` out clog2(BURST_BEEPS+1): remaining burst beeps, including the current one.

## Operation
- A press on key k is `key_flag[k] && !key_value[k]` in the same cycle. Flags with `key_value=1` (releases) are ignored.
- States: IDLE, CONT, BURST_ON, BURST_OFF.
- IDLE:
  - Toggle → CONT.
  - Burst → BURST_ON, `beeps_left=BURST_BEEPS`.
- CONT:
  - Toggle → IDLE.
  - Burst is ignored.
- BURST_ON / BURST_OFF:
  - Toggle → IDLE (abort), `beeps_left=0`.
  - Burst → BURST_ON with `beeps_left=BURST_BEEPS` (restart), phase counter cleared.
- BURST_ON: after `BEEP_ON_CYC` cycles in state → BURST_OFF.
- BURST_OFF: after `BEEP_OFF_CYC` cycles:
  - if `beeps_left>1`, → BURST_ON and decrement;
  - else → IDLE with `beeps_left=0`.
- Simultaneous toggle and burst presses: toggle wins, burst is dropped.
- Tone key: evaluated independently in every state, including together with other keys. Action: `tone_idx <= (tone_idx==NUM_TONES-1) ? 0 : tone_idx+1`.
- Audible = state is CONT or BURST_ON.
- Tone generator:
  - While not audible: counter = 0, square = 0.
  - While audible: counter increments each cycle. At `half(tone_idx)-1` the counter wraps to 0 and square toggles.
  - A tone change clears the counter but leaves square unchanged.
- `beep` <= square (tone build) or audible (level build), registered.

## Timing
- Reset values:
  - state = IDLE;
  - `beep=0`, `busy=0`, `tone_idx=0`, `beeps_left=0`;
  - all counters 0.
- Reset mid-burst or mid-tone returns to these values on the next edge. There is no residual output.
- State, `busy` and `beeps_left` update on the edge that samples the press: 1-cycle latency.
- Tone build: the first `beep` rise comes H+1 cycles after the state-entry edge, where H is the active half-period. High and low phases are then H cycles each.
- Level build: `beep` follows audible with 1 cycle of delay.
- Burst of B beeps lasts `B*BEEP_ON_CYC + B*BEEP_OFF_CYC` cycles from BURST_ON entry to IDLE. The trailing gap is included.
- Phase counter clears on every state change.

## Configuration
- `BEEP_TONE_EN` defined:
  - square-wave tone generation;
  - tone key active.
- `BEEP_TONE_EN` undefined (active-buzzer build):
  - `beep` is the registered audible level;
  - no tone generator is instantiated;
  - tone key is ignored;
  - `tone_idx` is held at 0.

## Structure
- `beep_pkg`:
  - state enum;
  - key index constants `KEY_TOGGLE=0`, `KEY_BURST=1`, `KEY_TONE=2`;
  - half-period function `BASE_HALF >> idx`.
- Sub-module `beep_tone_gen`: counter plus square toggle, with inputs `en`, `half`, `restart`. Instantiated only under `BEEP_TONE_EN`.

## Test plan
Bench parameters: `BASE_HALF=8`, `NUM_TONES=4`, `BURST_BEEPS=3`, `BEEP_ON_CYC=20`, `BEEP_OFF_CYC=10`, tone build.

- Reset, then toggle press:
  - `busy=1` next cycle;
  - `beep` high for 8 / low for 8 repeating, first rise 9 cycles after entry.
  - Second toggle press: `beep=0` and `busy=0` within 1 cycle.
- Burst press from IDLE:
  - three 20-cycle audible windows separated by 10-cycle silences;
  - `beeps_left` steps 3→2→1→0;
  - IDLE 90 cycles after entry.
- Burst restart and abort:
  - burst press during the second beep → `beeps_left=3`, full 3-beep sequence restarts;
  - toggle during BURST_OFF → IDLE, `beep=0`.
- Tone cycling: four tone presses in CONT → `tone_idx` 1, 2, 3, 0. Measured half-periods 4, 2, 1, 8.
- Simultaneous toggle and burst press in IDLE → CONT and `beeps_left=0`. Release flags (`key_value=1`) cause no state change.
- Reset asserted mid-burst → all outputs 0 next edge. Level build (`BEEP_TONE_EN` undefined): `beep` equals audible delayed by 1 cycle.
